// File: rtl/mem_responder.sv
// Word-addressed 16-bit data memory with a request/ready handshake.
// A programmable number of wait states lets the control FSM stall on slow memory.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        proc_rst,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [15:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       lat_data;
    logic              lat_write;
    logic              accept;
    logic              load_read;
    logic [15:0]       mem [DEPTH];

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[15:ADDR_W];

    // With no wait states the read address has to come straight from the bus,
    // since the latch is loaded on the same edge that enters RESP.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        load_read     = 1'b0;
        rd_addr       = lat_addr;
        case (state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    accept  = 1'b1;
                    rd_addr = mem_addr[ADDR_W-1:0];
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_RESP;
                        load_read  = !mem_write;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    wait_cnt_next = 4'd0;
                    state_next    = ST_RESP;
                    load_read     = !lat_write;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            lat_addr     <= '0;
            lat_data     <= 16'h0000;
            lat_write    <= 1'b0;
            mem_data_out <= 16'h0000;
            mem_err      <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                lat_addr  <= mem_addr[ADDR_W-1:0];
                lat_data  <= mem_data_in;
                lat_write <= mem_write;
                if (mem_read && mem_write) begin
                    mem_err <= 1'b1;
                end
            end
            if (load_read) begin
                mem_data_out <= mem[rd_addr];
            end
        end
    end

    // Array is never reset; a reset during WAIT/RESP forces IDLE so no write lands.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && lat_write) begin
            mem[lat_addr] <= lat_data;
        end
    end

    assign mem_ready = (state == ST_RESP);
    assign mem_busy  = (state != ST_IDLE);

endmodule
